// File: rtl/mem_ctrl_arbiter.sv
// rtl/mem_ctrl_arbiter.sv - two-master round-robin front end for a write-through cache and its RAM
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   reqN_valid/ready/addr/      request channel of master N (N=0,1); ready is combinational
//   reqN_wdata/wr
//   rspN_valid/rdata            one-cycle completion pulse and read data to master N
//   cache_addr/wdata/wr_en/     cache lookup, write-hit update and read-miss fill
//   fill_en/rdata/hit
//   ram_addr/wdata/wr_en/rdata  backing RAM access
//   busy, grant_id              transaction in flight and the port that owns it
module mem_ctrl_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_wr,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_wr,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_wr_en,
    output logic                  cache_fill_en,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    input  logic                  cache_hit,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  grant_id
);
    localparam int CW = $clog2(RAM_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RAM_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, LOOKUP, RAM_WAIT, RESPOND} state_t;

    state_t                state;
    logic                  last_grant;
    logic                  pick;
    logic                  accept;
    logic                  fin_hit;
    logic                  fin_ram;
    logic [DATA_WIDTH-1:0] fin_data;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] cache_wdata_q;
    logic [CW-1:0]         cnt;

    // On a tie the port not served last wins; otherwise whichever port is asking.
    always_comb begin
        pick = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !pick;
    assign req1_ready = (state == IDLE) && req1_valid && pick;
    assign accept     = req0_ready || req1_ready;

    // The fill has to carry RAM data in the same cycle it arrives, so the fill
    // cycle bypasses the data register; the register then holds that value.
    assign cache_wdata = cache_fill_en ? ram_rdata : cache_wdata_q;

    always_comb begin
        fin_hit  = (state == LOOKUP) && !wr_q && cache_hit;
        fin_ram  = (state == RAM_WAIT) && (cnt == '0);
        fin_data = fin_hit ? cache_rdata : (wr_q ? '0 : ram_rdata);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            cnt           <= '0;
            rsp0_valid    <= 1'b0;
            rsp0_rdata    <= '0;
            rsp1_valid    <= 1'b0;
            rsp1_rdata    <= '0;
            cache_addr    <= '0;
            cache_wdata_q <= '0;
            cache_wr_en   <= 1'b0;
            cache_fill_en <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            ram_wr_en     <= 1'b0;
            busy          <= 1'b0;
            grant_id      <= 1'b0;
        end else begin
            // Pulses and enables are registered for the state being entered.
            rsp0_valid    <= 1'b0;
            rsp1_valid    <= 1'b0;
            cache_wr_en   <= 1'b0;
            cache_fill_en <= 1'b0;
            ram_wr_en     <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q        <= pick ? req1_addr : req0_addr;
                        wdata_q       <= pick ? req1_wdata : req0_wdata;
                        wr_q          <= pick ? req1_wr : req0_wr;
                        grant_id      <= pick;
                        last_grant    <= pick;
                        cache_addr    <= pick ? req1_addr : req0_addr;
                        cache_wdata_q <= pick ? req1_wdata : req0_wdata;
                        cache_wr_en   <= pick ? req1_wr : req0_wr;
                        busy          <= 1'b1;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (!fin_hit) begin
                        cnt       <= CNT_LOAD;
                        ram_addr  <= addr_q;
                        ram_wdata <= wdata_q;
                        ram_wr_en <= wr_q;
                        // A one-cycle RAM wait is also the fill cycle.
                        cache_fill_en <= !wr_q && (CNT_LOAD == '0);
                        state     <= RAM_WAIT;
                    end
                end
                RAM_WAIT: begin
                    if (cnt != '0) begin
                        cnt           <= cnt - CNT_ONE;
                        cache_fill_en <= !wr_q && (cnt == CNT_ONE);
                    end else if (!wr_q) begin
                        cache_wdata_q <= ram_rdata;
                    end
                end
                RESPOND: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (fin_hit || fin_ram) begin
                state <= RESPOND;
                if (grant_id) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= fin_data;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= fin_data;
                end
            end
        end
    end
endmodule
